aes_encipher_lanes: RTL and testbench
=====================================

AES_ENCIPHER_LANES -- requirements
Module: aes_encipher_lanes

Interface
REQ-001 The block SHALL have parameter SBOX_LANES, default 1, giving the number of 32-bit words substituted per cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- next  in  1  start request, sampled only in IDLE.
- abort  in  1  synchronous cancel.
- keylen  in  2  key length: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = AES-128.
- round  out  4  current round index, used for the round-key lookup.
- round_key  in  128  round key for the current round.
- sboxw  out  32*SBOX_LANES  words to the S-box; lane i is at bits [32i+31:32i].
- new_sboxw  in  32*SBOX_LANES  S-box results, combinational, same lane order.
- block  in  128  plaintext, sampled during INIT.
- new_block  out  128  state/ciphertext {w0,w1,w2,w3}.
- ready  out  1  idle / result available.
- result_valid  out  1  one-cycle completion pulse.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states, IDLE, INIT, SBOX and MAIN, encoded in 2 bits.
REQ-005 In IDLE with next=1 and abort=0, the block SHALL do the following at the clock edge:
- latch keylen into keylen_reg;
- clear round_ctr to 0;
- drop ready to 0;
- move to INIT.
REQ-006 With next=0 in IDLE, the block SHALL hold all state; next asserted outside IDLE SHALL be ignored.
REQ-007 The round count Nr SHALL be taken from keylen_reg: 10, 12 or 14; the value 3 maps to 10. Changes on keylen mid-operation SHALL have no effect.
REQ-008 INIT (1 cycle) SHALL perform the following:
- write block XOR round_key (round=0) into all four words;
- increment round_ctr;
- clear sword_ctr;
- move to SBOX.
REQ-009 SBOX SHALL last S = 4/SBOX_LANES cycles, with sword_ctr counting 0..S-1.
- Each cycle, lane i SHALL carry word (sword_ctr*SBOX_LANES + i).
- Each returned lane SHALL be written to that same word.
- At sword_ctr = S-1, the FSM SHALL move to MAIN.
REQ-010 sword_ctr SHALL be 2 bits wide, increment by 1 and wrap. For SBOX_LANES=4 it SHALL stay at 0.
REQ-011 MAIN (1 cycle) SHALL always clear sword_ctr and increment round_ctr.
- If round_ctr < Nr: state = MixColumns(ShiftRows(state)) XOR round_key, then go to SBOX.
- Otherwise: state = ShiftRows(state) XOR round_key, ready=1, result_valid=1 for this one cycle, then go to IDLE.
REQ-012 MixColumns SHALL use GF(2^8) with polynomial 0x11B (xtime reduction constant 0x1b). ShiftRows SHALL follow the FIPS-197 column-major byte order.
REQ-013 Latency SHALL be 1 + Nr*(S+1) clock edges from the edge that accepts next to the edge that raises ready. Examples:
- 128-bit key, SBOX_LANES=1: 51 edges.
- 128-bit key, SBOX_LANES=4: 21 edges.
- 256-bit key, SBOX_LANES=1: 71 edges.
REQ-014 Outside the SBOX state, sboxw SHALL be all-zero.
REQ-015 new_block SHALL hold the ciphertext unchanged in IDLE until the next INIT.
REQ-016 Abort behaviour:
- abort=1 in INIT, SBOX or MAIN SHALL force IDLE at the next edge, set ready=1, keep result_valid=0, and clear all four words to 0.
- abort has priority over every other transition.
- abort in IDLE SHALL also block the start.
REQ-017 result_valid SHALL never be high for more than one consecutive cycle, and SHALL be high only when ready rises.
REQ-018 When a next arrives on the cycle after result_valid, a new operation SHALL start with no idle gap required.

Reset
REQ-019 While reset_n=0, the block SHALL be in the following state:
- state = IDLE, ready = 1, result_valid = 0;
- round_ctr = 0, sword_ctr = 0, keylen_reg = 0;
- new_block = 0 and sboxw = 0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation immediately, with no result_valid.

Verification
REQ-021 FIPS-197 C.1 test: AES-128, plaintext 00112233445566778899aabbccddeeff, key 000102..0f, SBOX_LANES=1. Required response: new_block = 69c4e0d86a7b0430d8cdb78070b4c55a, result_valid pulses exactly once, ready rises 51 edges after start.
REQ-022 FIPS-197 C.2 test: AES-192, same plaintext, key 000102..17, SBOX_LANES=2. Required response: new_block = dda97ca4864cdfe06eaf70a0ec0d7191, latency 37 edges.
REQ-023 FIPS-197 C.3 test: AES-256, key 000102..1f, SBOX_LANES=4. Required response: new_block = 8ea2b7ca516745bfeafc49904b496089, latency 29 edges.
REQ-024 Abort test: assert abort at round 5 during SBOX. Required response: ready=1 at the next edge, new_block=0, no result_valid; a following C.1 run still gives the correct result.
REQ-025 keylen test: toggle keylen from 0 to 2 mid-run of C.1. Required response: result still 69c4e0d86a7b0430d8cdb78070b4c55a with 10 rounds. A start with keylen=3 SHALL run 10 rounds.
REQ-026 Back-to-back and reset test: hold next=1 continuously. Required response: a new start on the cycle after each result_valid, with next ignored while busy. Asserting reset_n=0 mid-run SHALL give the REQ-019 values immediately.

Source files
------------

// File: rtl/aes_encipher_lanes.sv
// aes_encipher_lanes: iterative AES encryption datapath with external round keys and
// external S-boxes, substituting SBOX_LANES 32-bit words per cycle.
module aes_encipher_lanes #(
   parameter int SBOX_LANES = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    next,
   input  logic                    abort,
   input  logic [1:0]              keylen,
   output logic [3:0]              round,
   input  logic [127:0]            round_key,
   output logic [32*SBOX_LANES-1:0] sboxw,
   input  logic [32*SBOX_LANES-1:0] new_sboxw,
   input  logic [127:0]            block,
   output logic [127:0]            new_block,
   output logic                    ready,
   output logic                    result_valid
);
   localparam int S = 4 / SBOX_LANES;

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   state_t       state, state_n;
   logic [1:0]   keylen_reg, keylen_n, sword_ctr, sword_n;
   logic [3:0]   round_ctr, round_n, nr;
   logic [31:0]  w [4];
   logic [31:0]  w_n [4];
   logic         ready_n, valid_n, last;
   logic [127:0] st, sr, mc, rnd_out;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   // byte k = 4*col+row sits at [127-8k -: 8]; row r rotates left by r columns
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [1:0] lane(input logic [1:0] sc, input int i);
      return 2'(int'(sc) * SBOX_LANES + i);
   endfunction

   assign st        = {w[0], w[1], w[2], w[3]};
   assign sr        = shift_rows(st);
   assign mc        = {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};
   assign nr        = keylen_reg == 2'd1 ? 4'd12 : keylen_reg == 2'd2 ? 4'd14 : 4'd10;
   assign last      = round_ctr >= nr;
   assign rnd_out   = (last ? sr : mc) ^ round_key;
   assign round     = round_ctr;
   assign new_block = st;

   always_comb begin
      sboxw = '0;
      if (state == SBOX)
         for (int i = 0; i < SBOX_LANES; i++)
            sboxw[32*i +: 32] = w[lane(sword_ctr, i)];
   end

   always_comb begin
      state_n  = state;
      keylen_n = keylen_reg;
      round_n  = round_ctr;
      sword_n  = sword_ctr;
      w_n      = w;
      ready_n  = ready;
      valid_n  = 1'b0;
      if (abort && state != IDLE) begin
         state_n = IDLE;
         ready_n = 1'b1;
         sword_n = 2'd0;
         w_n     = '{default: '0};
      end else begin
         case (state)
            IDLE: if (next && !abort) begin
               keylen_n = keylen;
               round_n  = 4'd0;
               ready_n  = 1'b0;
               state_n  = INIT;
            end
            INIT: begin
               for (int k = 0; k < 4; k++)
                  w_n[k] = block[127-32*k -: 32] ^ round_key[127-32*k -: 32];
               round_n = round_ctr + 4'd1;
               sword_n = 2'd0;
               state_n = SBOX;
            end
            SBOX: begin
               for (int i = 0; i < SBOX_LANES; i++)
                  w_n[lane(sword_ctr, i)] = new_sboxw[32*i +: 32];
               sword_n = sword_ctr == 2'(S-1) ? 2'd0 : sword_ctr + 2'd1;
               state_n = sword_ctr == 2'(S-1) ? MAIN : SBOX;
            end
            MAIN: begin
               for (int k = 0; k < 4; k++)
                  w_n[k] = rnd_out[127-32*k -: 32];
               sword_n = 2'd0;
               round_n = round_ctr + 4'd1;
               ready_n = last;
               valid_n = last;
               state_n = last ? IDLE : SBOX;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         keylen_reg   <= 2'd0;
         round_ctr    <= 4'd0;
         sword_ctr    <= 2'd0;
         w            <= '{default: '0};
         ready        <= 1'b1;
         result_valid <= 1'b0;
      end else begin
         state        <= state_n;
         keylen_reg   <= keylen_n;
         round_ctr    <= round_n;
         sword_ctr    <= sword_n;
         w            <= w_n;
         ready        <= ready_n;
         result_valid <= valid_n;
      end
   end
endmodule

// File: tb/tb_aes_encipher_lanes.sv
// tb_aes_encipher_lanes: runs 1-, 2- and 4-lane instances side by side against FIPS-197
// vectors and a byte-level AES reference model with its own key schedule and S-box.
module tb_aes_encipher_lanes;
   logic         clk = 0, reset_n = 0, next = 0, abort = 0;
   logic [1:0]   keylen = 0;
   logic [127:0] blk = 0;
   logic [2:0]   rdy, rv, sw_zero;
   logic [2:0][127:0] nb;
   logic [2:0][3:0]   rnd;
   logic [7:0]   sbox [256];
   logic [127:0] rk_tab [16];
   int           checks = 0, errors = 0;

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_lane
      localparam int L = 1 << g;
      logic [32*L-1:0] sw, nsw;
      logic [3:0]      r;
      logic [127:0]    rkey;
      always_comb rkey = rk_tab[r];
      always_comb begin
         nsw = '0;
         for (int i = 0; i < 4*L; i++) nsw[8*i +: 8] = sbox[sw[8*i +: 8]];
      end
      aes_encipher_lanes #(.SBOX_LANES(L)) dut (
         .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
         .round(r), .round_key(rkey), .sboxw(sw), .new_sboxw(nsw), .block(blk),
         .new_block(nb[g]), .ready(rdy[g]), .result_valid(rv[g]));
      assign rnd[g]     = r;
      assign sw_zero[g] = sw == '0;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0, x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      logic [15:0] t;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         t = {inv, inv};
         s = inv ^ 8'h63;
         for (int n = 1; n <= 4; n++) s ^= t[15-n -: 8];
         sbox[x] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
   endfunction

   task automatic set_key(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 60; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) t = sub_word(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk_tab[15] = '0;
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [127:0] o;
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_tab[0][127-8*k -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c+r] = rd == nr ? t[4*c+r] :
                  gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
         for (int k = 0; k < 16; k++) s[k] ^= rk_tab[rd][127-8*k -: 8];
      end
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
      return o;
   endfunction

   function automatic int nr_of(input logic [1:0] kl);
      return kl == 2'd1 ? 12 : kl == 2'd2 ? 14 : 10;
   endfunction

   function automatic int nk_of(input logic [1:0] kl);
      return kl == 2'd1 ? 6 : kl == 2'd2 ? 8 : 4;
   endfunction

   task automatic run_op(input string tag, input logic [127:0] pt, input logic [1:0] kl,
                         input int nr, input logic [127:0] exp, input int mid_kl);
      int lat [3];
      int pul [3];
      lat = '{-1, -1, -1};
      pul = '{0, 0, 0};
      blk = pt;
      keylen = kl;
      @(negedge clk) next = 1;
      @(posedge clk);
      #1 next = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (c == 5 && mid_kl >= 0) keylen = 2'(mid_kl);
         for (int g = 0; g < 3; g++) begin
            if (rv[g]) pul[g]++;
            if (rdy[g] && lat[g] < 0) begin
               lat[g] = c;
               check({tag, "_rv_at_ready"}, rv[g], 1);
               check({tag, "_ct"}, nb[g], exp);
            end
         end
         if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0 && c >= lat[0] + 2) break;
      end
      for (int g = 0; g < 3; g++) begin
         check({tag, "_latency"}, lat[g], 1 + nr * ((4 >> g) + 1));
         check({tag, "_pulses"}, pul[g], 1);
         check({tag, "_ct_held"}, nb[g], exp);
         check({tag, "_sboxw_idle"}, sw_zero[g], 1);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, rdy, 3'b111);
      check({tag, "_rv"}, rv, 3'b000);
      for (int g = 0; g < 3; g++) begin
         check({tag, "_nb"}, nb[g], 0);
         check({tag, "_round"}, rnd[g], 0);
         check({tag, "_sboxw"}, sw_zero[g], 1);
      end
   endtask

   initial begin
      logic [2:0]   busy, seen, prev;
      int           cnt [3];
      logic [1:0]   kl;
      logic [255:0] key;
      logic [127:0] pt;
      build_sbox();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      reset_n = 1;
      repeat (3) @(negedge clk);
      check("idle_hold_ready", rdy, 3'b111);

      set_key(K1, 4); run_op("c1", PT, 2'd0, 10, C1, -1);
      set_key(K2, 6); run_op("c2", PT, 2'd1, 12, C2, -1);
      set_key(K3, 8); run_op("c3", PT, 2'd2, 14, C3, -1);
      set_key(K1, 4); run_op("kl_toggle", PT, 2'd0, 10, C1, 2);
      set_key(K1, 4); run_op("kl3", PT, 2'd3, 10, C1, -1);

      // abort in the 1-lane instance during the SBOX phase of round 5
      blk = PT;
      keylen = 0;
      @(negedge clk) next = 1;
      @(posedge clk);
      #1 next = 0;
      for (int c = 0; c < 100 && rnd[0] != 4'd5; c++) begin
         @(posedge clk);
         #1;
      end
      check("abort_round", rnd[0], 5);
      busy = ~rdy;
      check("abort_busy", busy[0], 1);
      abort = 1;
      @(posedge clk);
      #1 abort = 0;
      seen = 0;
      for (int g = 0; g < 3; g++)
         if (busy[g]) begin
            check("abort_ready", rdy[g], 1);
            check("abort_nb", nb[g], 0);
            check("abort_rv", rv[g], 0);
            check("abort_sboxw", sw_zero[g], 1);
         end
      repeat (60) begin
         @(posedge clk);
         #1 seen |= rv & busy;
      end
      check("abort_no_rv", seen, 0);
      run_op("post_abort", PT, 2'd0, 10, C1, -1);

      repeat (6) begin
         kl = 2'($urandom_range(0, 3));
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt = {$urandom, $urandom, $urandom, $urandom};
         set_key(key, nk_of(kl));
         run_op("rand", pt, kl, nr_of(kl), ref_enc(pt, nr_of(kl)), -1);
      end

      // next held high: each instance restarts on the cycle after every result
      set_key(K1, 4);
      blk = PT;
      keylen = 0;
      prev = 0;
      cnt = '{0, 0, 0};
      @(negedge clk) next = 1;
      for (int c = 0; c <= 160; c++) begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 3; g++) begin
            if (prev[g]) check("b2b_restart", rdy[g], 0);
            if (rv[g]) begin
               cnt[g]++;
               check("b2b_ct", nb[g], C1);
            end
         end
         prev = rv;
      end
      for (int g = 0; g < 3; g++) check("b2b_pulses", cnt[g], 161 / (2 + 10 * ((4 >> g) + 1)));
      #2 reset_n = 0;
      #1 check_reset("midrun_reset");
      next = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
